booth_r4_mac: RTL and testbench

Parametrised sequential radix-4 Booth multiply-accumulate unit. It is the next generation of the radix-2 Booth multiplier plus 40-bit adder MAC.
- Supports configurable operand and accumulator widths.
- Runs signed or unsigned multiplication, selected per operation.
- Accumulates with a per-operation clear, and saturates or wraps on overflow.
- Uses valid/ready handshakes on both input and output.
- Sits between the operand sequencer and the result writeback stage of the MAC pipeline.

---
 rtl/mac_pkg.sv | 25 ++
 rtl/booth_r4_recoder.sv | 31 +++
 rtl/booth_r4_mac.sv | 139 +++++++++++++
 tb/tb_booth_r4_mac.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the radix-4 Booth multiply-accumulate unit.
package mac_pkg;

   localparam int unsigned MAX_W = 128;

   typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;
   typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_t;

   function automatic int unsigned iter_count(input int unsigned width);
      return (width + 2) / 2;
   endfunction

   // Clamp a sign-extended exact sum into the signed range of 'width' bits.
   function automatic logic [MAX_W-1:0] sat_clamp(input logic [MAX_W-1:0] sum,
                                                  input int unsigned width);
      logic [MAX_W-1:0] max_v;
      logic [MAX_W-1:0] min_v;
      max_v = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
      min_v = ~max_v;
      if ($signed(sum) > $signed(max_v)) return max_v;
      if ($signed(sum) < $signed(min_v)) return min_v;
      return sum;
   endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: triplet {q1,q0,q_prev} to digit and selected multiple of M.
module booth_r4_recoder
   import mac_pkg::*;
#(
   parameter int unsigned XW = 18
) (
   input  logic [2:0]    triplet,
   input  logic [XW-1:0] m,
   output booth_digit_t  digit,
   output logic [XW:0]   multiple
);

   logic [XW:0] m1;
   logic [XW:0] m2;

   assign m1 = {m[XW-1], m};
   assign m2 = {m, 1'b0};

   always_comb begin
      digit    = ZERO;
      multiple = '0;
      case (triplet)
         3'b001, 3'b010: begin digit = P1; multiple = m1;  end
         3'b011:         begin digit = P2; multiple = m2;  end
         3'b100:         begin digit = M2; multiple = -m2; end
         3'b101, 3'b110: begin digit = M1; multiple = -m1; end
         default:        begin digit = ZERO; multiple = '0; end
      endcase
   end

endmodule

// File: rtl/booth_r4_mac.sv
// Sequential radix-4 Booth multiplier with saturating/wrapping accumulator and
// valid/ready handshakes on both sides.
module booth_r4_mac
   import mac_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ACC_WIDTH  = 40,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_a,
   input  logic [DATA_WIDTH-1:0]   in_b,
   input  logic                    in_signed,
   input  logic                    in_acc_clr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] prod_out,
   output logic [ACC_WIDTH-1:0]    acc_out,
   output logic                    ovf_out
);

   localparam int unsigned XW   = DATA_WIDTH + 2;
   localparam int unsigned PW   = XW + 2;
   localparam int unsigned PRW  = 2 * DATA_WIDTH;
   localparam int unsigned ITER = iter_count(DATA_WIDTH);
   localparam int unsigned CW   = $clog2(ITER + 1);

   if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc
      $error("booth_r4_mac: ACC_WIDTH must be at least 2*DATA_WIDTH");
   end
   if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_bad_data
      $error("booth_r4_mac: DATA_WIDTH must be even and at least 4");
   end
   if (ACC_WIDTH + 2 > MAX_W || 2 * XW > MAX_W) begin : g_bad_max
      $error("booth_r4_mac: widths exceed internal arithmetic width");
   end

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [XW-1:0]   m_reg;
   logic [PW-1:0]   p;
   logic [XW-1:0]   q;
   logic            q_prev;
   logic            clr_reg;

   booth_digit_t    digit;
   logic [XW:0]     multiple;
   logic [XW-1:0]   a_ext;
   logic [XW-1:0]   b_ext;
   logic [PW-1:0]   p_sum;
   logic [2*XW-1:0] prod_full;
   logic [MAX_W-1:0] prod_w;
   logic [MAX_W-1:0] acc_w;
   logic [MAX_W-1:0] sum_w;
   logic [MAX_W-1:0] clamped;
   logic             ovf_c;

   booth_r4_recoder #(.XW(XW)) u_recoder (
      .triplet  ({q[1:0], q_prev}),
      .m        (m_reg),
      .digit    (digit),
      .multiple (multiple)
   );

   assign a_ext = in_signed ? {{2{in_a[DATA_WIDTH-1]}}, in_a} : {2'b00, in_a};
   assign b_ext = in_signed ? {{2{in_b[DATA_WIDTH-1]}}, in_b} : {2'b00, in_b};

   // Partial-product add and exact accumulate in a wide signed domain.
   always_comb begin
      p_sum     = (digit == ZERO) ? p : p + PW'($signed(multiple));
      prod_full = {p[XW-1:0], q};
      prod_w    = MAX_W'($signed(prod_full));
      acc_w     = MAX_W'($signed(acc_out));
      sum_w     = (clr_reg ? '0 : acc_w) + prod_w;
      clamped   = sat_clamp(sum_w, ACC_WIDTH);
      ovf_c     = (clamped != sum_w);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         prod_out  <= '0;
         acc_out   <= '0;
         ovf_out   <= 1'b0;
         cnt       <= '0;
         m_reg     <= '0;
         p         <= '0;
         q         <= '0;
         q_prev    <= 1'b0;
         clr_reg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  m_reg    <= a_ext;
                  q        <= b_ext;
                  p        <= '0;
                  q_prev   <= 1'b0;
                  clr_reg  <= in_acc_clr;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               {p, q} <= {{2{p_sum[PW-1]}}, p_sum, q[XW-1:2]};
               q_prev <= q[1];
               if (cnt == CW'(ITER - 1)) begin
                  cnt   <= '0;
                  state <= ACC;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ACC: begin
               prod_out  <= prod_full[PRW-1:0];
               acc_out   <= SATURATE ? clamped[ACC_WIDTH-1:0] : sum_w[ACC_WIDTH-1:0];
               ovf_out   <= ovf_c;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_r4_mac.sv
// Directed bench for booth_r4_mac: default 40-bit instance plus 33-bit saturating
// and wrapping instances driven by the same stimulus.
module tb_booth_r4_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_signed;
   logic        in_acc_clr;
   logic        out_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;

   logic        m_in_ready, m_out_valid, m_ovf;
   logic [31:0] m_prod;
   logic [39:0] m_acc;
   logic        s_in_ready, s_out_valid, s_ovf;
   logic [31:0] s_prod;
   logic [32:0] s_acc;
   logic        w_in_ready, w_out_valid, w_ovf;
   logic [31:0] w_prod;
   logic [32:0] w_acc;

   int total = 0;
   int bad   = 0;
   int cyc;
   int pulses;
   logic [63:0] hold_prod;
   logic [63:0] hold_acc;
   logic [63:0] pos_acc [4];
   logic [63:0] neg_acc [5];

   booth_r4_mac u_main (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc_clr(in_acc_clr),
      .out_valid(m_out_valid), .out_ready(out_ready),
      .prod_out(m_prod), .acc_out(m_acc), .ovf_out(m_ovf)
   );

   booth_r4_mac #(.DATA_WIDTH(16), .ACC_WIDTH(33), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc_clr(in_acc_clr),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .prod_out(s_prod), .acc_out(s_acc), .ovf_out(s_ovf)
   );

   booth_r4_mac #(.DATA_WIDTH(16), .ACC_WIDTH(33), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc_clr(in_acc_clr),
      .out_valid(w_out_valid), .out_ready(out_ready),
      .prod_out(w_prod), .acc_out(w_acc), .ovf_out(w_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic c);
      int n;
      n = 0;
      while (!m_in_ready && n < 50) begin
         tick();
         n++;
      end
      in_a = a; in_b = b; in_signed = s; in_acc_clr = c; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int c);
      c = 1;
      while (!m_out_valid && c < 40) begin
         tick();
         c++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      pos_acc = '{64'h040000000, 64'h080000000, 64'h0C0000000, 64'h0FFFFFFFF};
      neg_acc = '{64'h1C0008000, 64'h180010000, 64'h140018000, 64'h100020000, 64'h100000000};
      rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_acc_clr = 1'b0;
      out_ready = 1'b0; in_a = '0; in_b = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready", m_in_ready, 1);
      chk("rst_out_valid", m_out_valid, 0);
      chk("rst_prod", m_prod, 0);
      chk("rst_acc", m_acc, 0);
      chk("rst_ovf", m_ovf, 0);

      // signed 3 * -5 with clear
      start_op(16'd3, 16'hFFFB, 1'b1, 1'b1);
      wait_out(cyc);
      chk("t1_latency", cyc, 11);
      chk("t1_prod", m_prod, 64'hFFFFFFF1);
      chk("t1_acc", m_acc, 64'hFFFFFFFFF1);
      chk("t1_ovf", m_ovf, 0);
      release_out();
      chk("t1_idle_ready", m_in_ready, 1);

      start_op(16'h8000, 16'h8000, 1'b1, 1'b0);
      wait_out(cyc);
      chk("t2_latency", cyc, 11);
      chk("t2_prod", m_prod, 64'h40000000);
      chk("t2_acc", m_acc, 64'h003FFFFFF1);
      release_out();

      start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      wait_out(cyc);
      chk("t3u_prod", m_prod, 64'hFFFE0001);
      chk("t3u_acc", m_acc, 64'h00FFFE0001);
      chk("t3u_ovf", m_ovf, 0);
      release_out();

      start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      wait_out(cyc);
      chk("t3s_prod", m_prod, 64'h00000001);
      chk("t3s_acc", m_acc, 64'h00FFFE0002);
      release_out();

      // back-pressure: outputs hold and a concurrent request is ignored
      start_op(16'hFFFE, 16'd7, 1'b1, 1'b0);
      wait_out(cyc);
      chk("t5_prod", m_prod, 64'hFFFFFFF2);
      chk("t5_acc", m_acc, 64'h00FFFDFFF4);
      hold_prod = 64'(m_prod);
      hold_acc  = 64'(m_acc);
      in_a = 16'h1234; in_b = 16'h5678; in_acc_clr = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_hold_prod", m_prod, 64'hFFFFFFF2);
         chk("t5_hold_acc", m_acc, 64'h00FFFDFFF4);
         chk("t5_hold_valid", m_out_valid, 1);
         chk("t5_hold_ready", m_in_ready, 0);
      end
      in_valid = 1'b0;
      release_out();
      chk("t5_rel_ready", m_in_ready, 1);
      chk("t5_rel_valid", m_out_valid, 0);
      chk("t5_idle_prod", m_prod, hold_prod);
      chk("t5_idle_acc", m_acc, hold_acc);

      // reset during the fourth CALC iteration
      start_op(16'd100, 16'd100, 1'b1, 1'b0);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_in_ready", m_in_ready, 1);
      chk("t6_out_valid", m_out_valid, 0);
      chk("t6_acc", m_acc, 0);
      chk("t6_prod", m_prod, 0);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (m_out_valid) pulses++;
      end
      chk("t6_no_pulse", pulses, 0);
      start_op(16'd2, 16'd3, 1'b1, 1'b0);
      wait_out(cyc);
      chk("t6_latency", cyc, 11);
      chk("t6_prod", m_prod, 6);
      chk("t6_acc", m_acc, 6);
      release_out();

      // 33-bit accumulators: positive overflow after four 2^30 products
      for (int i = 0; i < 4; i++) begin
         start_op(16'h8000, 16'h8000, 1'b1, (i == 0));
         wait_out(cyc);
         chk("t4_sat_acc", s_acc, pos_acc[i]);
         chk("t4_sat_ovf", s_ovf, (i == 3));
         chk("t4_wrap_ovf", w_ovf, (i == 3));
         if (i < 3) chk("t4_wrap_acc", w_acc, pos_acc[i]);
         else       chk("t4_wrap_acc", w_acc, 64'h100000000);
         release_out();
      end
      chk("t4_main_acc", m_acc, 64'h0100000000);
      chk("t4_main_ovf", m_ovf, 0);

      // negative overflow on the fifth -2^30+2^15 product
      for (int i = 0; i < 5; i++) begin
         start_op(16'h8000, 16'h7FFF, 1'b1, (i == 0));
         wait_out(cyc);
         chk("neg_prod", m_prod, 64'hC0008000);
         chk("neg_sat_acc", s_acc, neg_acc[i]);
         chk("neg_sat_ovf", s_ovf, (i == 4));
         if (i < 4) chk("neg_wrap_acc", w_acc, neg_acc[i]);
         else       chk("neg_wrap_acc", w_acc, 64'h0C0028000);
         chk("neg_wrap_ovf", w_ovf, (i == 4));
         release_out();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
